regfile_mp: RTL and testbench

//  Parametrised multi-read-port integer register file for the RISC-V core.

---
 rtl/regfile_mp.sv | 56 +++++
 tb/tb_regfile_mp.sv | 128 ++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with x0 hardwired to zero, write bypass,
// pending-write scoreboard and a sequenced bulk-clear FSM.
module regfile_mp #(
   parameter int XLEN = 32,
   parameter int NREGS = 32,
   parameter int NRD = 2,
   parameter int BYPASS = 1,
   localparam int AW = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear_req,
   output logic                ready,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                busy_set,
   input  logic [AW-1:0]       busy_addr,
   output logic [NREGS-1:0]    busy
);
   typedef enum logic {READY, CLEAR} state_t;
   state_t state;
   logic [AW-1:0] idx;
   logic [XLEN-1:0] regs [NREGS];
   assign ready = state == READY;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= READY;
         idx <= '0;
         busy <= '0;
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      end else if (state == CLEAR) begin
         regs[idx] <= '0;
         busy[idx] <= 1'b0;
         idx <= idx + 1'b1;
         if (idx == AW'(NREGS - 1)) state <= READY;
      end else begin
         if (clear_req) begin
            state <= CLEAR;
            idx <= AW'(1);
         end
         if (wr_en && wr_addr != '0) regs[wr_addr] <= wr_data;
         if (wr_en) busy[wr_addr] <= 1'b0;
         // Placed after the clear so a newly issued producer wins over a retiring one.
         if (busy_set && busy_addr != '0) busy[busy_addr] <= 1'b1;
      end
   end
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] a;
      assign a = rd_addr[i*AW +: AW];
      assign rd_data[i*XLEN +: XLEN] = (a == '0) ? '0 :
         (BYPASS != 0 && ready && wr_en && wr_addr == a) ? wr_data : regs[a];
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven vectors checked through a scoreboard queue, plus clear/reset sequences.
module tb_regfile_mp;
   logic clk = 0, reset = 1, clear_req = 0, wr_en = 0, busy_set = 0, ready;
   logic [9:0] rd_addr = '0;
   logic [63:0] rd_data;
   logic [4:0] wr_addr = '0, busy_addr = '0;
   logic [31:0] wr_data = '0, busy;
   int tests = 0, fails = 0;

   typedef struct {
      logic we; logic [4:0] wa; logic [31:0] wd;
      logic bs; logic [4:0] ba; logic cr;
      logic [4:0] ra0, ra1;
      logic [31:0] e0, e1, eb; logic erdy;
   } vec_t;
   typedef struct {
      logic [31:0] e0, e1, eb; logic erdy; string name;
   } exp_t;
   exp_t sb[$];
   vec_t tbl[13];

   regfile_mp dut (
      .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready),
      .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy_set(busy_set), .busy_addr(busy_addr), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic void chk(string n, logic [31:0] act, logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, act, expv);
      end
   endfunction

   function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic bs, logic [4:0] ba,
                               logic cr, logic [4:0] ra0, logic [4:0] ra1,
                               logic [31:0] e0, logic [31:0] e1, logic [31:0] eb, logic erdy);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.bs = bs; v.ba = ba; v.cr = cr;
      v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1; v.eb = eb; v.erdy = erdy;
      return v;
   endfunction

   task automatic apply(vec_t v, string n);
      exp_t e;
      wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
      busy_set = v.bs; busy_addr = v.ba; clear_req = v.cr;
      rd_addr = {v.ra1, v.ra0};
      e.e0 = v.e0; e.e1 = v.e1; e.eb = v.eb; e.erdy = v.erdy; e.name = n;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({e.name, ".rd0"}, rd_data[31:0], e.e0);
         chk({e.name, ".rd1"}, rd_data[63:32], e.e1);
         chk({e.name, ".busy"}, busy, e.eb);
         chk({e.name, ".ready"}, {31'b0, ready}, {31'b0, e.erdy});
      end
   end

   initial begin
      tbl[0]  = mk(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 1);
      tbl[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 1);
      tbl[3]  = mk(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 1);
      tbl[5]  = mk(0, 0, 0, 1, 7, 0, 7, 5, 0, 32'hDEADBEEF, 0, 1);
      tbl[6]  = mk(1, 7, 32'h77, 1, 7, 0, 7, 7, 32'h77, 32'h77, 32'h80, 1);
      tbl[7]  = mk(1, 7, 32'h88, 0, 0, 0, 7, 3, 32'h88, 0, 32'h80, 1);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0, 7, 5, 32'h88, 32'hDEADBEEF, 0, 1);
      tbl[9]  = mk(1, 3, 3, 1, 9, 0, 3, 9, 3, 0, 0, 1);
      tbl[10] = mk(0, 0, 0, 0, 0, 0, 3, 9, 3, 0, 32'h200, 1);
      tbl[11] = mk(1, 9, 32'h99, 0, 0, 0, 9, 9, 32'h99, 32'h99, 32'h200, 1);
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 9, 3, 32'h99, 3, 0, 1);

      #2;
      for (int a = 0; a < 32; a++) begin
         rd_addr = {5'(31 - a), 5'(a)};
         #1;
         chk($sformatf("rst.rd0[%0d]", a), rd_data[31:0], 0);
         chk($sformatf("rst.rd1[%0d]", 31 - a), rd_data[63:32], 0);
      end
      chk("rst.ready", {31'b0, ready}, 1);
      chk("rst.busy", busy, 0);
      @(posedge clk);
      #1;
      reset = 0;

      for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("vec%0d", i));

      for (int i = 1; i < 32; i++)
         apply(mk(1, 5'(i), i, 0, 0, 0, 5'(i), 5'(i - 1), i, i - 1, 0, 1), $sformatf("fill%0d", i));
      apply(mk(0, 0, 0, 0, 0, 1, 5, 6, 5, 6, 0, 1), "clr_start");
      for (int j = 0; j < 31; j++)
         apply(mk(1, 31, 32'hFFFF, 1, 2, 1, 5'(j + 1), 31, j + 1, 31, 0, 0), $sformatf("clr%0d", j));
      apply(mk(0, 0, 0, 0, 0, 0, 31, 1, 0, 0, 0, 1), "clr_done");
      for (int a = 0; a < 32; a += 2)
         apply(mk(0, 0, 0, 0, 0, 0, 5'(a), 5'(a + 1), 0, 0, 0, 1), $sformatf("post_clr%0d", a));

      apply(mk(1, 20, 5, 0, 0, 0, 20, 20, 5, 5, 0, 1), "x20_wr");
      apply(mk(0, 0, 0, 0, 0, 1, 20, 0, 5, 0, 0, 1), "clr2_start");
      for (int j = 0; j < 9; j++)
         apply(mk(0, 0, 0, 0, 0, 0, 20, 5'(j + 1), 5, 0, 0, 0), $sformatf("clr2_%0d", j));
      rd_addr = {5'd20, 5'd20};
      reset = 1;
      #1;
      chk("mid_rst.ready", {31'b0, ready}, 1);
      chk("mid_rst.rd0", rd_data[31:0], 0);
      chk("mid_rst.rd1", rd_data[63:32], 0);
      chk("mid_rst.busy", busy, 0);
      @(posedge clk);
      #1;
      reset = 0;
      apply(mk(0, 0, 0, 0, 0, 0, 20, 11, 0, 0, 0, 1), "after_rst");
      apply(mk(1, 12, 32'hABC, 0, 0, 0, 12, 20, 32'hABC, 0, 0, 1), "after_rst_wr");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
